// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit serialiser between N_REQ byte streams.
// Grants last for a whole packet, up to MAX_BURST bytes, or until the owner stalls for STALL_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_byte,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_byte,
  output logic                 tx_send,
  input  logic                 tx_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_TIMEOUT);
  localparam logic [7:0]    BURST_LIM = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ISSUE, SENT, WAIT} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [7:0]      burst_q, burst_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            last_q, last_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_send_q, tx_send_d;

  // First valid requester strictly after the pointer, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] v, input logic [IW-1:0] p);
    logic [IW-1:0] pick;
    logic          found;
    pick  = p;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      int idx;
      idx = (int'(p) + i) % N_REQ;
      if (!found && v[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(N_REQ - 1);
      gidx_q    <= '0;
      burst_q   <= '0;
      stall_q   <= '0;
      last_q    <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      burst_q   <= burst_d;
      stall_q   <= stall_d;
      last_q    <= last_d;
      tx_byte_q <= tx_byte_d;
      tx_send_q <= tx_send_d;
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    burst_d   = burst_q;
    stall_d   = stall_q;
    last_d    = last_q;
    tx_byte_d = tx_byte_q;
    tx_send_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        burst_d = '0;
        stall_d = '0;
        // The serialiser may still be shifting after a reset, so wait for tx_ready.
        if (|req_valid && tx_ready) begin
          gidx_d  = rr_pick(req_valid, ptr_q);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_ready && req_valid[gidx_q]) begin
          tx_byte_d = req_byte[{gidx_q, 3'b000} +: 8];
          tx_send_d = 1'b1;
          burst_d   = burst_q + 8'd1;
          stall_d   = '0;
          last_d    = req_last[gidx_q];
          state_d   = SENT;
        end else if (!req_valid[gidx_q] && STALL_TIMEOUT != 0) begin
          stall_d = stall_q + 1'b1;
          if (stall_d == STALL_LIM) begin
            ptr_d   = gidx_q;
            state_d = IDLE;
          end
        end
      end
      SENT: state_d = WAIT;
      WAIT: begin
        if (tx_ready) begin
          if (last_q || burst_q == BURST_LIM) begin
            ptr_d   = gidx_q;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    req_ready = '0;
    if (state_q != IDLE) grant[gidx_q] = 1'b1;
    if (state_q == ISSUE && tx_ready) req_ready[gidx_q] = 1'b1;
    busy    = |grant;
    tx_byte = tx_byte_q;
    tx_send = tx_send_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle table for the stall timeout path, then
// packet-level sequences against a serialiser model and per-requester byte queues.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_byte;
  logic [7:0]     tx_byte;
  logic           tx_send, tx_ready, busy;

  logic [N-1:0]   nt_valid, nt_last, nt_req_ready, nt_grant;
  logic [8*N-1:0] nt_byte;
  logic [7:0]     nt_tx_byte;
  logic           nt_tx_send, nt_busy;
  logic           nt_tx_ready;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(16), .STALL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_byte(req_byte), .req_last(req_last),
    .req_ready(req_ready), .tx_byte(tx_byte), .tx_send(tx_send), .tx_ready(tx_ready),
    .grant(grant), .busy(busy));

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(16), .STALL_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .req_valid(nt_valid), .req_byte(nt_byte), .req_last(nt_last),
    .req_ready(nt_req_ready), .tx_byte(nt_tx_byte), .tx_send(nt_tx_send), .tx_ready(nt_tx_ready),
    .grant(nt_grant), .busy(nt_busy));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serialiser model and requester queues
  bit          model_on, drv_on;
  int          frame, ser_cnt, cyc;
  logic [8:0]  rq_mem [N][64];
  int          rq_head [N];
  int          rq_tail [N];
  logic [7:0]  log_byte[$];
  int          log_idx[$];
  int          log_cyc[$];

  function automatic int oh2i(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic push(input int i, input logic [7:0] b, input logic l);
    rq_mem[i][rq_tail[i]] = {l, b};
    rq_tail[i]++;
  endtask

  // Advance one clock; called mid-cycle, returns 2 time units after the next rising edge.
  task automatic tick();
    logic [N-1:0] fire;
    logic         sent, prev_send, prev_rdy;
    fire      = req_valid & req_ready;
    sent      = tx_send;
    prev_send = tx_send;
    prev_rdy  = tx_ready;
    @(posedge clk); #1;
    cyc++;
    if (model_on) begin
      if (sent) ser_cnt = frame;
      else if (ser_cnt > 0) ser_cnt--;
      tx_ready = (ser_cnt == 0);
    end
    if (drv_on) begin
      for (int i = 0; i < N; i++) begin
        if (fire[i] && rq_head[i] < rq_tail[i]) rq_head[i]++;
        req_valid[i]       = (rq_head[i] < rq_tail[i]);
        req_byte[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
        req_last[i]        = rq_mem[i][rq_head[i]][8];
      end
    end
    #1;
    if (tx_send) begin
      check("send_not_back_to_back", prev_send, 1'b0);
      check("tx_ready_high_before_send", prev_rdy, 1'b1);
      log_byte.push_back(tx_byte);
      log_idx.push_back(oh2i(grant));
      log_cyc.push_back(cyc);
    end
    if (req_ready != '0) check("ready_only_to_owner", req_ready & ~grant, '0);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_byte = '0;
    nt_valid = '0; nt_last = '0; nt_byte = '0;
    tx_ready = 1'b1; ser_cnt = 0;
    for (int i = 0; i < N; i++) begin rq_head[i] = 0; rq_tail[i] = 0; end
    log_byte.delete(); log_idx.delete(); log_cyc.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (log_byte.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, log_byte.size(), n);
  endtask

  typedef struct {
    logic [N-1:0] v, l;
    logic         r;
    logic [N-1:0] g, rdy;
    logic         s;
    logic [7:0]   b;
  } vec_t;

  vec_t tbl[18];
  logic [7:0] exp_b[42];
  int         exp_i[42];

  initial begin
    nt_tx_ready = 1'b1;
    model_on = 1'b0; drv_on = 1'b0; frame = 0; cyc = 0;

    // Reset values
    reset_all();
    check("reset_grant", grant, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_tx_send", tx_send, 1'b0);
    check("reset_tx_byte", tx_byte, 8'h00);
    check("reset_req_ready", req_ready, '0);

    // Cycle table: req0 sends one byte, stalls 8 ISSUE cycles, then req1 sends a 1-byte packet
    tbl[0]  = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 8'h00};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'h41};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'h41};
    tbl[4]  = '{4'b0010, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'h41};
    for (int i = 5; i <= 12; i++)
      tbl[i] = '{4'b0010, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 8'h41};
    tbl[13] = '{4'b0010, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h41};
    tbl[14] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0, 8'h41};
    tbl[15] = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'h55};
    tbl[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h55};
    tbl[17] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h55};

    reset_all();
    req_byte = {8'h00, 8'h00, 8'h55, 8'h41};
    for (int i = 0; i < 18; i++) begin
      req_valid = tbl[i].v;
      req_last  = tbl[i].l;
      tx_ready  = tbl[i].r;
      #1;
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      check($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].rdy);
      check($sformatf("tbl%0d_tx_send", i), tx_send, tbl[i].s);
      check($sformatf("tbl%0d_tx_byte", i), tx_byte, tbl[i].b);
      @(posedge clk); #1;
    end

    model_on = 1'b1; drv_on = 1'b1;

    // A: single requester, 3-byte packet, 10-cycle frames
    reset_all();
    frame = 10;
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    run_until("A_send_count", 3, 200);
    for (int i = 0; i < 3 && i < log_byte.size(); i++) begin
      check($sformatf("A_byte%0d", i), log_byte[i], 8'h41 + 8'(i));
      check($sformatf("A_owner%0d", i), log_idx[i], 0);
      if (i > 0) check($sformatf("A_spacing%0d", i), (log_cyc[i] - log_cyc[i-1]) >= 10, 1'b1);
    end
    repeat (15) tick();
    check("A_grant_released", grant, '0);
    check("A_busy_released", busy, 1'b0);

    // B: req0 and req2 alternate at packet granularity
    reset_all();
    frame = 2;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    run_until("B_send_count", 6, 300);
    begin
      logic [7:0] bb [6];
      int         bi [6];
      bb = '{8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'hA2, 8'hA3};
      bi = '{0, 0, 2, 2, 0, 0};
      for (int i = 0; i < 6 && i < log_byte.size(); i++)
        check($sformatf("B_entry%0d", i), {log_idx[i][7:0], log_byte[i]}, {bi[i][7:0], bb[i]});
    end

    // C: req1 streams 40 bytes without last, req3 waits; bursts capped at 16
    reset_all();
    frame = 0;
    for (int i = 0; i < 40; i++) push(1, 8'(i), 1'b0);
    push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1);
    for (int k = 0; k < 42; k++) begin
      if (k < 16)      begin exp_b[k] = 8'(k);        exp_i[k] = 1; end
      else if (k < 18) begin exp_b[k] = 8'hD0 + 8'(k - 16); exp_i[k] = 3; end
      else             begin exp_b[k] = 8'(k - 2);    exp_i[k] = 1; end
    end
    run_until("C_send_count", 42, 800);
    for (int k = 0; k < 42 && k < log_byte.size(); k++)
      check($sformatf("C_entry%0d", k), {log_idx[k][7:0], log_byte[k]}, {exp_i[k][7:0], exp_b[k]});

    // D: slow serialiser, 50-cycle frames
    reset_all();
    frame = 50;
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    run_until("D_send_count", 3, 400);
    for (int i = 1; i < 3 && i < log_byte.size(); i++)
      check($sformatf("D_spacing%0d", i), (log_cyc[i] - log_cyc[i-1]) > 50, 1'b1);

    // E: reset while waiting on a busy serialiser
    reset_all();
    frame = 20;
    push(0, 8'h5A, 1'b0); push(0, 8'h5B, 1'b0);
    run_until("E_first_send", 1, 50);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("E_rst_tx_send", tx_send, 1'b0);
    check("E_rst_grant", grant, '0);
    check("E_rst_busy", busy, 1'b0);
    check("E_rst_tx_byte", tx_byte, 8'h00);
    begin
      int early, k;
      early = 0; k = 0;
      while (!tx_ready && k < 40) begin
        tick();
        k++;
        if (grant != '0) early++;
      end
      check("E_no_grant_while_serialiser_busy", early, 0);
      check("E_serialiser_ready_seen", tx_ready, 1'b1);
      tick();
      check("E_grant_after_ready", grant, 4'b0001);
    end

    // F: STALL_TIMEOUT=0 holds the grant through an indefinite stall
    model_on = 1'b0; drv_on = 1'b0;
    reset_all();
    nt_valid = 4'b0001; nt_byte = {8'h00, 8'h00, 8'h62, 8'h61}; nt_last = '0;
    begin
      int k;
      logic seen1;
      k = 0;
      while (!nt_req_ready[0] && k < 10) begin tick(); k++; end
      check("F_req0_offered", nt_req_ready[0], 1'b1);
      tick();
      nt_valid = 4'b0010;
      seen1 = 1'b0;
      repeat (40) begin
        tick();
        seen1 |= nt_req_ready[1];
      end
      check("F_grant_held", nt_grant, 4'b0001);
      check("F_req1_never_ready", seen1, 1'b0);
      check("F_byte_sent", nt_tx_byte, 8'h61);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
